// File: rtl/mult_hilo_unit_if.sv
// Signal bundle between EX-stage control, the HI/LO unit and the multiplier array.
// The slave side is the HI/LO unit; the master side is whoever drives requests and the array.
interface mult_hilo_unit_if;
  logic        start;
  logic        is_signed;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wr_data;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_z;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, is_signed, op_a, op_b, wr_hi, wr_lo, wr_data, mul_z,
    input  mul_a, mul_b, busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, op_a, op_b, wr_hi, wr_lo, wr_data, mul_z,
    output mul_a, mul_b, busy, done, hi, lo
  );
endinterface

// File: rtl/mult_hilo_unit.sv
// MULT/MULTU control and HI/LO writeback around a pipelined 32x32 unsigned multiplier array.
// The array only sees magnitudes; the sign is reapplied to the 64-bit product at writeback.
module mult_hilo_unit #(
  parameter int unsigned MUL_LAT = 1  // array latency in cycles, 1..15
) (
  input  logic            clk,
  input  logic            reset,
  mult_hilo_unit_if.slave bus
);
  typedef enum logic {StIdle, StWait} state_e;

  localparam logic [3:0] LastCnt = 4'(MUL_LAT);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        neg_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] mul_a_q;
  logic [31:0] mul_b_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        neg_d;
  logic [63:0] result;

  // -0x80000000 wraps back to 0x80000000, which is the correct unsigned magnitude.
  always_comb begin
    mag_a  = (bus.is_signed && bus.op_a[31]) ? (~bus.op_a + 32'd1) : bus.op_a;
    mag_b  = (bus.is_signed && bus.op_b[31]) ? (~bus.op_b + 32'd1) : bus.op_b;
    neg_d  = bus.is_signed & (bus.op_a[31] ^ bus.op_b[31]);
    result = neg_q ? (~bus.mul_z + 64'd1) : bus.mul_z;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mul_a_q <= 32'd0;
      mul_b_q <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // A same-edge start still lets the direct write land; the product overwrites it later.
          if (bus.wr_hi) hi_q <= bus.wr_data;
          if (bus.wr_lo) lo_q <= bus.wr_data;
          if (bus.start) begin
            mul_a_q <= mag_a;
            mul_b_q <= mag_b;
            neg_q   <= neg_d;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b1;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (cnt_q == LastCnt) begin
            {hi_q, lo_q} <= result;
            done_q       <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= StIdle;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
      endcase
    end
  end

  assign bus.mul_a = mul_a_q;
  assign bus.mul_b = mul_b_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
endmodule

// File: tb/tb_mult_hilo_unit.sv
// Directed bench for mult_hilo_unit: one instance with MUL_LAT=1, one with MUL_LAT=3,
// each fed by a register-pipeline model of the multiplier array.
module tb_mult_hilo_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  mult_hilo_unit_if b1 ();
  mult_hilo_unit_if b3 ();

  mult_hilo_unit #(.MUL_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  mult_hilo_unit #(.MUL_LAT(3)) dut3 (.clk(clk), .reset(reset), .bus(b3));

  always #5 clk = ~clk;

  logic [63:0] pipe1;
  logic [63:0] pipe3 [3];
  always @(posedge clk) begin
    pipe1    <= {32'd0, b1.mul_a} * {32'd0, b1.mul_b};
    pipe3[0] <= {32'd0, b3.mul_a} * {32'd0, b3.mul_b};
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign b1.mul_z = pipe1;
  assign b3.mul_z = pipe3[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete multiply on the MUL_LAT=1 instance, checked cycle by cycle.
  task automatic run1(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ma, input logic [31:0] mb, input logic [63:0] want);
    b1.start = 1'b1;
    b1.is_signed = sgn;
    b1.op_a = a;
    b1.op_b = b;
    tick();
    b1.start = 1'b0;
    chk({tag, ".busy_e0"}, 64'(b1.busy), 64'd1);
    chk({tag, ".mul_a"}, 64'(b1.mul_a), 64'(ma));
    chk({tag, ".mul_b"}, 64'(b1.mul_b), 64'(mb));
    tick();
    chk({tag, ".busy_e1"}, 64'(b1.busy), 64'd1);
    chk({tag, ".done_e1"}, 64'(b1.done), 64'd0);
    tick();
    chk({tag, ".done_e2"}, 64'(b1.done), 64'd1);
    chk({tag, ".busy_e2"}, 64'(b1.busy), 64'd0);
    chk({tag, ".hilo"}, {b1.hi, b1.lo}, want);
    tick();
    chk({tag, ".done_e3"}, 64'(b1.done), 64'd0);
  endtask

  initial begin
    b1.start = 1'b0; b1.is_signed = 1'b0; b1.op_a = '0; b1.op_b = '0;
    b1.wr_hi = 1'b0; b1.wr_lo = 1'b0; b1.wr_data = '0;
    b3.start = 1'b0; b3.is_signed = 1'b0; b3.op_a = '0; b3.op_b = '0;
    b3.wr_hi = 1'b0; b3.wr_lo = 1'b0; b3.wr_data = '0;

    repeat (2) tick();
    chk("rst.hilo", {b1.hi, b1.lo}, 64'd0);
    chk("rst.busy", 64'(b1.busy), 64'd0);
    chk("rst.done", 64'(b1.done), 64'd0);
    chk("rst.mul_ab", {b1.mul_a, b1.mul_b}, 64'd0);
    chk("rst.busy3", 64'(b3.busy), 64'd0);
    reset = 1'b0;
    tick();
    chk("idle.done", 64'(b1.done), 64'd0);

    run1("multu_ff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
         64'hFFFF_FFFE_0000_0001);
    run1("mult_m3x5", 1'b1, 32'hFFFF_FFFD, 32'd5, 32'd3, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
    run1("mult_minx1", 1'b1, 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd1,
         64'hFFFF_FFFF_8000_0000);
    run1("mult_minxmin", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
         64'h4000_0000_0000_0000);
    run1("multu_minxmin", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
         64'h4000_0000_0000_0000);
    run1("mult_0xm7", 1'b1, 32'd0, 32'hFFFF_FFF9, 32'd0, 32'd7, 64'd0);

    // Start and MTHI while busy are both dropped, including on the capture edge.
    b1.start = 1'b1; b1.is_signed = 1'b0; b1.op_a = 32'd2; b1.op_b = 32'd3;
    tick();
    b1.op_a = 32'd9; b1.op_b = 32'd9; b1.wr_hi = 1'b1; b1.wr_data = 32'hAAAA_5555;
    tick();
    chk("busy_ign.mul_a", 64'(b1.mul_a), 64'd2);
    tick();
    chk("busy_ign.done", 64'(b1.done), 64'd1);
    chk("busy_ign.hilo", {b1.hi, b1.lo}, 64'd6);
    b1.start = 1'b0; b1.wr_hi = 1'b0;
    tick();
    chk("busy_ign.done_once", 64'(b1.done), 64'd0);
    chk("busy_ign.not_queued", 64'(b1.busy), 64'd0);
    chk("busy_ign.hilo_hold", {b1.hi, b1.lo}, 64'd6);

    b1.wr_hi = 1'b1; b1.wr_lo = 1'b1; b1.wr_data = 32'h1234_5678;
    tick();
    b1.wr_hi = 1'b0; b1.wr_lo = 1'b0;
    chk("mthilo.hilo", {b1.hi, b1.lo}, 64'h1234_5678_1234_5678);
    chk("mthilo.no_done", 64'(b1.done), 64'd0);

    b1.wr_lo = 1'b1; b1.wr_data = 32'hDEAD_BEEF;
    b1.start = 1'b1; b1.op_a = 32'h0001_0000; b1.op_b = 32'h0001_0000;
    tick();
    b1.wr_lo = 1'b0; b1.start = 1'b0;
    chk("wr_start.lo_first", {b1.hi, b1.lo}, 64'h1234_5678_DEAD_BEEF);
    tick();
    tick();
    chk("wr_start.done", 64'(b1.done), 64'd1);
    chk("wr_start.hilo", {b1.hi, b1.lo}, 64'h0000_0001_0000_0000);
    tick();

    // Asynchronous reset mid-operation.
    b1.start = 1'b1; b1.op_a = 32'd7; b1.op_b = 32'd7;
    tick();
    b1.start = 1'b0;
    chk("areset.busy_before", 64'(b1.busy), 64'd1);
    #3 reset = 1'b1;
    #1;
    chk("areset.busy", 64'(b1.busy), 64'd0);
    chk("areset.done", 64'(b1.done), 64'd0);
    chk("areset.hilo", {b1.hi, b1.lo}, 64'd0);
    chk("areset.mul_ab", {b1.mul_a, b1.mul_b}, 64'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("areset.no_stale_done", 64'(b1.done), 64'd0);
    run1("after_reset", 1'b0, 32'd4, 32'd4, 32'd4, 32'd4, 64'd16);

    // MUL_LAT=3 instance: busy across E0..E4, then back-to-back start in the done cycle.
    b3.start = 1'b1; b3.is_signed = 1'b1; b3.op_a = 32'hFFFF_FFFE; b3.op_b = 32'd100;
    tick();
    b3.start = 1'b0;
    chk("lat3.mul_ab", {b3.mul_a, b3.mul_b}, {32'd2, 32'd100});
    for (int i = 0; i < 4; i++) begin
      chk("lat3.busy", 64'(b3.busy), 64'd1);
      chk("lat3.done_early", 64'(b3.done), 64'd0);
      tick();
    end
    chk("lat3.done", 64'(b3.done), 64'd1);
    chk("lat3.busy_clr", 64'(b3.busy), 64'd0);
    chk("lat3.hilo", {b3.hi, b3.lo}, 64'hFFFF_FFFF_FFFF_FF38);
    b3.start = 1'b1; b3.is_signed = 1'b0; b3.op_a = 32'd6; b3.op_b = 32'd7;
    tick();
    b3.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("lat3b.busy", 64'(b3.busy), 64'd1);
      chk("lat3b.done_early", 64'(b3.done), 64'd0);
      tick();
    end
    chk("lat3b.done", 64'(b3.done), 64'd1);
    chk("lat3b.hilo", {b3.hi, b3.lo}, 64'd42);
    tick();
    chk("lat3b.done_clr", 64'(b3.done), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
